// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder (data_mem_ctrl).
package dmem_pkg;

  // Controller states: accept a request, count wait states, present the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } dmem_state_e;

  // Access size decoded from funct3.
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } dmem_size_e;

  // RISC-V load/store funct3 encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte lanes per 32-bit word.
  localparam int LANES = 4;

  // Unused encodings (011, 110, 111) fall through to a word access.
  function automatic dmem_size_e size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = SZ_B;
      F3_H, F3_HU: size_of = SZ_H;
      default:     size_of = SZ_W;
    endcase
  endfunction

  // Half on an odd byte, or word off a word boundary.
  function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] lo);
    case (size_of(funct3))
      SZ_H:    misaligned = lo[0];
      SZ_W:    misaligned = (lo != 2'b00);
      default: misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load-path lane select with sign or zero extension of the selected byte/half.
module load_extend
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        fill_b;
  logic        fill_h;

  // Pick the addressed lane, then extend according to size and signedness.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (that would infer a latch).
    byte_sel = word[7:0];
    case (lane)
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      2'd3:    byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
    // funct3[2] marks the unsigned variants BU/HU.
    fill_b   = byte_sel[7] & ~funct3[2];
    fill_h   = half_sel[15] & ~funct3[2];
    data     = word;
    case (size_of(funct3))
      SZ_B:    data = {{24{fill_b}}, byte_sel};
      SZ_H:    data = {{16{fill_h}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory responder for the MEM stage: word array with byte-lane stores,
// extended loads and WAIT_CYCLES wait states, stalling the pipeline meanwhile.
// Optional feature: define DMEM_MISALIGN_TRAP_EN to flag misaligned H/W
// accesses (no write, zero load data) instead of silently aligning them.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic        misalign_o
);

  localparam int         IDX_W   = $clog2(DEPTH_WORDS);
  localparam int         AW      = IDX_W + 2;
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  dmem_state_e state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        req;
  logic        take;
  logic        last;
  logic        access;

  // Request captured in IDLE; the pipeline holds its inputs, but the block
  // works from its own copy once it leaves IDLE.
  logic [2:0]    req_f3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          req_store;

  // Operands of the access edge: live inputs when zero wait states let the
  // access happen on the accepting edge, otherwise the captured request.
  logic [2:0]    acc_f3;
  logic [AW-1:0] acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_store;
  dmem_size_e    acc_size;
  logic [1:0]    eff_lo;
  logic          acc_mis;

  logic [IDX_W-1:0] idx;
  logic [LANES-1:0] be;
  logic [31:0]      st_data;
  logic             we;
  logic [31:0]      rd_word;
  logic [31:0]      ld_data;

  logic [31:0] mem [DEPTH_WORDS];

  // Upper address bits beyond the array wrap and are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^addr_i[31:AW];

  // A store wins when both request lines are high.
  assign req     = mem_read_i | mem_write_i;
  assign stall_o = ((state == IDLE) & req) | (state == WAIT);
  assign done_o  = (state == DONE);
  assign last    = (cnt <= 4'd1);
  assign access  = (take & (WAIT_LD == 4'd0)) | ((state == WAIT) & last);

  // Next-state and wait-state counter logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    take    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          take  = 1'b1;
          cnt_n = WAIT_LD;
          if (WAIT_LD == 4'd0) state_n = DONE;
          else                 state_n = WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (last) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register and wait-state counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_ni) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Capture the request when it is accepted in IDLE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_f3    <= F3_W;
      req_addr  <= '0;
      req_wdata <= '0;
      req_store <= 1'b0;
    end else if (take) begin
      req_f3    <= funct3_i;
      req_addr  <= addr_i[AW-1:0];
      req_wdata <= wdata_i;
      req_store <= mem_write_i;
    end
  end

  // Select access operands and resolve the effective low address bits.
  always_comb begin
    if (state == IDLE) begin
      acc_f3    = funct3_i;
      acc_addr  = addr_i[AW-1:0];
      acc_wdata = wdata_i;
      acc_store = mem_write_i;
    end else begin
      acc_f3    = req_f3;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_store = req_store;
    end
    acc_size = size_of(acc_f3);
`ifdef DMEM_MISALIGN_TRAP_EN
    acc_mis = misaligned(acc_f3, acc_addr[1:0]);
    eff_lo  = acc_addr[1:0];
`else
    // Halves drop addr[0] and words drop addr[1:0].
    acc_mis = 1'b0;
    case (acc_size)
      SZ_B:    eff_lo = acc_addr[1:0];
      SZ_H:    eff_lo = {acc_addr[1], 1'b0};
      default: eff_lo = 2'b00;
    endcase
`endif
  end

  assign idx = acc_addr[AW-1:2];

  // Store lane enables and replicated store data.
  always_comb begin
    be      = 4'b1111;
    st_data = acc_wdata;
    case (acc_size)
      SZ_B: begin
        be      = 4'b0001 << eff_lo;
        st_data = {4{acc_wdata[7:0]}};
      end
      SZ_H: begin
        be      = 4'b0011 << {eff_lo[1], 1'b0};
        st_data = {2{acc_wdata[15:0]}};
      end
      default: begin
        be      = 4'b1111;
        st_data = acc_wdata;
      end
    endcase
  end

  assign we = access & acc_store & ~acc_mis;

  // Byte-enabled array write.
  always_ff @(posedge clk_i) begin
    // NOTE: the array has no reset; its contents are undefined until written, which keeps it mappable to RAM.
    if (we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  assign rd_word = mem[idx];

  load_extend u_load_extend (
    .funct3 (acc_f3),
    .lane   (eff_lo),
    .word   (rd_word),
    .data   (ld_data)
  );

  // Load result register: updated on the access edge of a load only
  // (a trapped misaligned access clears it instead).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_o <= '0;
    end else if (access) begin
      if (acc_mis)         rdata_o <= '0;
      else if (!acc_store) rdata_o <= ld_data;
    end
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_q;

  // Remember the misalignment of the access so it can pulse with done.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     mis_q <= 1'b0;
    else if (access) mis_q <= acc_mis;
  end

  assign misalign_o = (state == DONE) & mis_q;
`else
  assign misalign_o = 1'b0;
`endif

endmodule
